// File: rtl/adaptive_threshold.sv
// Binarise each pixel against its local box-filter mean minus a constant.
// Streams one pixel per clock; reads land one clock after the address.
module adaptive_threshold #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int OFFSET      = 5,
  parameter int INVERT      = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oMeanCol,
  output logic [HEIGHT_BITS-1:0] oMeanRow,
  input  logic [7:0]             iMeanData,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  output logic [7:0]             oResultData,
  output logic                   oResultWren,
  output logic                   finished
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [WIDTH_BITS-1:0]  COL_MAX = '1;
  localparam logic [HEIGHT_BITS-1:0] ROW_MAX = '1;
  localparam logic [9:0]             OFF_W   = 10'(OFFSET);
  localparam logic                   INV     = (INVERT != 0);

  state_t                   state_q, state_d;
  logic [WIDTH_BITS-1:0]    col_q, col_d;
  logic [HEIGHT_BITS-1:0]   row_q, row_d;
  logic                     drain_q, drain_d;

  logic                     v1_q;
  logic [WIDTH_BITS-1:0]    col1_q;
  logic [HEIGHT_BITS-1:0]   row1_q;

  logic                     wren_q;
  logic [WIDTH_BITS-1:0]    rcol_q;
  logic [HEIGHT_BITS-1:0]   rrow_q;
  logic [7:0]               rdata_q;

  logic [9:0]               lhs;
  logic                     fg;
  logic [7:0]               pix_out;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (col_q == COL_MAX && row_q == ROW_MAX) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          col_d = col_q + 1'b1;
          if (col_q == COL_MAX) begin
            row_d = row_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
    end
  end

  // Zero-extended compare: a small mean never underflows into a pass.
  always_comb begin
    lhs     = {2'b00, iImageData} + OFF_W;
    fg      = lhs > {2'b00, iMeanData};
    pix_out = (fg ^ INV) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_q   <= 1'b0;
      col1_q <= '0;
      row1_q <= '0;
    end else begin
      v1_q   <= (state_q == RUN);
      col1_q <= col_q;
      row1_q <= row_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wren_q  <= 1'b0;
      rcol_q  <= '0;
      rrow_q  <= '0;
      rdata_q <= '0;
    end else begin
      wren_q <= v1_q;
      if (v1_q) begin
        rcol_q  <= col1_q;
        rrow_q  <= row1_q;
        rdata_q <= pix_out;
      end
    end
  end

  assign oImageCol   = col_q;
  assign oImageRow   = row_q;
  assign oMeanCol    = col_q;
  assign oMeanRow    = row_q;
  assign oResultCol  = rcol_q;
  assign oResultRow  = rrow_q;
  assign oResultData = rdata_q;
  assign oResultWren = wren_q;
  assign finished    = (state_q == DONE);

endmodule

// File: doc/adaptive_threshold.md
Name: adaptive_threshold

Overview:
- Final pixel stage, directly downstream of box_filter; started when box_filter asserts finished.
- Scans the image row-major and reads each original pixel from the input ROM and its local mean from the middle RAM.
- Writes a binary pixel (255/0) into the result RAM.
- Sustains 1 pixel/clock with a fixed 2-cycle pipeline.

Parameters:
- WIDTH_BITS, 7, column address width; WIDTH = 2**WIDTH_BITS.
- HEIGHT_BITS, 7, row address width; HEIGHT = 2**HEIGHT_BITS.
- OFFSET, 5, threshold constant C (0..255) subtracted from mean.
- INVERT, 0, 0: foreground=255 when pixel > mean-C; 1: outputs swapped.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level; sampled in IDLE/DONE; driven from box_filter finished.
- oImageCol  out  WIDTH_BITS  input ROM column address.
- oImageRow  out  HEIGHT_BITS  input ROM row address.
- iImageData  in  8  input ROM data, valid 1 clock after address.
- oMeanCol  out  WIDTH_BITS  middle RAM read column.
- oMeanRow  out  HEIGHT_BITS  middle RAM read row.
- iMeanData  in  8  middle RAM read data, valid 1 clock after address.
- oResultCol  out  WIDTH_BITS  result RAM write column.
- oResultRow  out  HEIGHT_BITS  result RAM write row.
- oResultData  out  8  0x00 or 0xFF.
- oResultWren  out  1  write strobe, one clock per pixel.
- finished  out  1  high in DONE.

Behaviour:
- Reset (reset=0, async): state=IDLE. All address outputs are 0, oResultData=0, oResultWren=0, finished=0, and the pipeline valid bits are cleared.
- Reset asserted mid-run aborts immediately; no further writes occur.
- States:
  - IDLE: start=1 moves to RUN with col=row=0.
  - RUN: presents (col,row) on both read ports each clock. col increments; on col wrap (WIDTH-1 to 0) row increments. After issuing (WIDTH-1,HEIGHT-1) it moves to DRAIN.
  - DRAIN: 2 clocks, no new addresses, pipeline empties. Then DONE.
  - DONE: finished=1, address outputs hold their last values. start=1 clears finished, resets col/row to 0 and enters RUN; the next frame's first address is issued that same clock.
- start is ignored in RUN/DRAIN.
- oImageCol/Row and oMeanCol/Row are always identical.
- Pipeline timing:
  - Cycle t: address A issued.
  - Cycle t+1: both data words for A are valid; A is carried in a delay register together with a valid bit.
  - Cycle t+2 (registered): oResultWren=1, oResult{Col,Row}=A, oResultData=decision.
- Latency address to write is exactly 2 clocks. Back-to-back writes occur with no gaps across row boundaries.
- Decision arithmetic, 10-bit signed, no wrap:
  - fg = ({2'b0,pixel} + OFFSET) > {2'b0,mean}, which is equivalent to pixel > mean - C.
  - Equality gives fg=0.
  - mean < OFFSET always gives fg=1 (no underflow).
  - oResultData = (fg XOR INVERT) ? 8'hFF : 8'h00.
- Outside valid write cycles: oResultWren=0, and oResultData/Col/Row hold their last values.
- Total writes per frame: exactly WIDTH*HEIGHT, each address exactly once, in row-major order.
- finished rises on the clock after the last write (last write at DRAIN cycle 2; DONE on the following edge).
- Cycles from start-sample to finished=1: WIDTH*HEIGHT+3.

Test Plan:
1. 128x128. ROM all 100, middle RAM all 100, OFFSET=5 -> 16384 writes, all 0xFF; first write (0,0) 3 clocks after start sampled; last write (127,127); finished high 16387 clocks after start.
2. Boundary: pixel=95, mean=100, OFFSET=5 at (3,0) -> 0x00. pixel=96 at (4,0) -> 0xFF. INVERT=1 at the same two pixels -> 0xFF and 0x00.
3. Underflow: mean=2, pixel=0, OFFSET=5 -> 0xFF. mean=255, pixel=255, OFFSET=0 -> 0x00.
4. Ordering/wrap: ROM[c,r]=c, RAM=0, OFFSET=0 -> writes strictly row-major; (127,0) followed next clock by (0,1); (0,r) gives 0x00 and every other column gives 0xFF; no Wren gaps.
5. Reset mid-run: pull reset low at pixel 5000 -> Wren=0 and finished=0 asynchronously, before the next edge. After release, no writes until start. Restart produces 16384 fresh writes.
6. Restart from DONE: hold start=1 in DONE -> finished drops next edge and a second full frame runs identically. start pulsed during RUN -> ignored; write count stays 16384.
